// File: rtl/user_mstr_arbiter.sv
// Two-master round-robin arbiter for the native valid/ready bus: merges CPU (m0) and
// selected user master (m1) onto one downstream port, with ownership lock and timeout watchdog.
module user_mstr_arbiter #(
  parameter int          TIMEOUT_CYC = 256,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        usr_en_i,
  input  logic        m0_valid_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_wstrb_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ready_o,
  input  logic        m1_valid_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_wstrb_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ready_o,
  output logic        s_valid_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_wstrb_o,
  input  logic [31:0] s_rdata_i,
  input  logic        s_ready_i,
  output logic [1:0]  owner_o,
  output logic        timeout_o
);

  // Handshake: a master holds valid and its payload stable until it sees a 1-cycle ready;
  // the downstream slave answers a held s_valid_o with a 1-cycle s_ready_i.

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;   // 0 = m0, 1 = m1
  logic          last_q, last_d;
  logic [TW-1:0] timer_q;

  logic        req0, req1, own_valid, busy;
  logic        abort, done, expire, resp_ready;
  logic [31:0] resp_data;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      // Cleared while idle so every transaction starts its watchdog from zero
      if (state_q == IDLE) timer_q <= '0;
      else                 timer_q <= timer_q + 1'b1;
    end
  end

  always_comb begin
    req0      = m0_valid_i;
    req1      = m1_valid_i & usr_en_i;
    busy      = (state_q == BUSY);
    own_valid = owner_q ? req1 : req0;
    // A vanished owner request (disable or protocol violation) is dropped silently
    abort     = busy & ~own_valid;
    done      = busy & own_valid & s_ready_i;
    expire    = busy & own_valid & ~s_ready_i & (timer_q == T_LAST);

    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = BUSY;
          owner_d = (req0 & req1) ? ~last_q : req1;
        end
      end
      BUSY: begin
        if (abort) begin
          state_d = IDLE;
        end else if (done | expire) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase

    resp_ready = done | expire;
    resp_data  = done ? s_rdata_i : (expire ? ERR_RDATA : 32'h0);

    s_valid_o = busy;
    s_addr_o  = busy ? (owner_q ? m1_addr_i  : m0_addr_i)  : 32'h0;
    s_wdata_o = busy ? (owner_q ? m1_wdata_i : m0_wdata_i) : 32'h0;
    s_wstrb_o = busy ? (owner_q ? m1_wstrb_i : m0_wstrb_i) : 4'h0;

    m0_ready_o = resp_ready & ~owner_q;
    m1_ready_o = resp_ready &  owner_q;
    m0_rdata_o = m0_ready_o ? resp_data : 32'h0;
    m1_rdata_o = m1_ready_o ? resp_data : 32'h0;

    owner_o   = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    timeout_o = expire;
  end

endmodule
